mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous instruction/data memory between the CPU fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the core pipeline and the unified memory. Issues one access at a time with req/gnt/rvalid handshakes.
- Tracks the fixed memory read latency with a counter, then returns data to the owning requester.

Parameters:
ADDR_WIDTH, 8, byte address width; matches core PC width
DATA_WIDTH, 32, data/instruction word width
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..7

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
if_req  in  1  IFU read request
if_addr  in  ADDR_WIDTH  IFU fetch address
if_gnt  out  1  IFU request accepted this cycle
if_rvalid  out  1  IFU read data valid
if_rdata  out  DATA_WIDTH  IFU read data
ls_req  in  1  LSU request
ls_we  in  1  LSU write enable (1 = store)
ls_be  in  DATA_WIDTH/8  LSU byte enables
ls_addr  in  ADDR_WIDTH  LSU address
ls_wdata  in  DATA_WIDTH  LSU store data
ls_gnt  out  1  LSU request accepted this cycle
ls_rvalid  out  1  LSU response (load data or store ack)
ls_rdata  out  DATA_WIDTH  LSU load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_be  out  DATA_WIDTH/8  memory byte enables
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data
busy  out  1  access outstanding

Behaviour:
- State: IDLE, BUSY. Registers:
  - owner (IF/LS)
  - owner_we
  - lat_cnt, 3 bits
  - last_gnt (used by the RR option)
- Reset (rst==0 at a rising edge), values after the edge:
  - state=IDLE, lat_cnt=0, owner=IF, last_gnt=IF.
  - All gnt/rvalid/mem_en/mem_we/busy are 0; rdata outputs are 0.
  - Any outstanding access is abandoned; no rvalid is produced for it.
- Slot free (free) = state==IDLE, or (state==BUSY and lat_cnt==MEM_LATENCY).
- Grant, combinational in a free cycle:
  - LSU has fixed priority: ls_gnt = free & ls_req.
  - if_gnt = free & if_req & ~ls_req.
  - At most one gnt is high per cycle.
- Grant cycle T:
  - mem_en=1.
  - mem_addr/we/be/wdata come from the winner combinationally. For the IFU: we=0, be=all ones, wdata=0.
  - At the edge: state=BUSY, lat_cnt=1, owner and owner_we latched.
  - No grant → mem_en=0, all other mem_* outputs 0.
- BUSY: lat_cnt increments each cycle until it equals MEM_LATENCY.
- Response cycle T+MEM_LATENCY (lat_cnt==MEM_LATENCY):
  - The owner's rvalid=1 for exactly one cycle.
  - Owner's rdata = mem_rdata (pass-through), or 0 if owner_we (store ack).
  - The non-owner's rdata is 0.
  - A new grant may issue in this same cycle (back-to-back). Peak throughput: one access per MEM_LATENCY cycles.
- Response cycle without a new grant: next state is IDLE.
- busy = (state==BUSY).
- Requester rules:
  - req, address and write fields must be held stable until gnt.
  - req may drop before gnt with no effect.
  - Deasserting req after gnt does not cancel the access.
- Simultaneous if_req & ls_req in a free cycle: LSU wins (fixed priority); IFU waits.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: on conflict (both req in a free cycle), the requester that is not last_gnt wins. last_gnt updates on every grant, so after reset the first conflict goes to LS. With a single requester, it wins regardless of last_gnt.
- Undefined: fixed LSU priority as above. last_gnt logic is absent and no starvation protection exists.

Test Plan:
- Reset, then rst=1; MEM_LATENCY=1. IFU reads 0x04, mem_rdata=0x00500093:
  - if_gnt=1 and mem_en=1 in the same cycle.
  - Next cycle if_rvalid=1, if_rdata=0x00500093.
  - busy=1 for one cycle.
- MEM_LATENCY=2, if_req and ls_req (load 0x40) both high continuously, macro undefined:
  - ls_gnt first.
  - ls_rvalid 2 cycles later, with if_gnt in that same cycle.
  - if_rvalid 2 cycles after that.
  - if_gnt never coincides with ls_gnt.
- Store: ls_we=1, be=4'b0011, addr=0x20, wdata=0xDEADBEEF:
  - mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF in the grant cycle.
  - ls_rvalid=1 with ls_rdata=0 after MEM_LATENCY.
- ARB_ROUND_ROBIN_EN defined, both requesters held high for 6 grants: order LS, IF, LS, IF, LS, IF. Undefined: LS on every grant.
- rst=0 asserted while BUSY (lat_cnt=1, MEM_LATENCY=3):
  - After the edge, busy=0 and mem_en=0.
  - No rvalid is ever produced for the aborted access.
  - The first request after release is granted immediately.
- Requester pulses req for one cycle while BUSY, then drops it before free: no grant and no mem_en is produced.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - IFU/LSU request ports and memory bus of the shared memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                      if_req;
  logic [ADDR_WIDTH-1:0]     if_addr;
  logic                      if_gnt;
  logic                      if_rvalid;
  logic [DATA_WIDTH-1:0]     if_rdata;

  logic                      ls_req;
  logic                      ls_we;
  logic [DATA_WIDTH/8-1:0]   ls_be;
  logic [ADDR_WIDTH-1:0]     ls_addr;
  logic [DATA_WIDTH-1:0]     ls_wdata;
  logic                      ls_gnt;
  logic                      ls_rvalid;
  logic [DATA_WIDTH-1:0]     ls_rdata;

  logic                      mem_en;
  logic                      mem_we;
  logic [DATA_WIDTH/8-1:0]   mem_be;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  logic                      busy;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_be, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between IFU and LSU with fixed-latency response tracking.
// Optional ARB_ROUND_ROBIN_EN alternates the winner on conflicts instead of fixed LSU priority.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam int         BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] LAT      = 3'(MEM_LATENCY);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_LS} owner_t;

  state_t                state, state_next;
  owner_t                owner, owner_next;
  logic                  owner_we, owner_we_next;
  logic [2:0]            lat_cnt, lat_cnt_next;

  logic                  resp, free, ls_pick, if_gnt, ls_gnt, gnt;
  logic                  we_mux;
  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [BE_WIDTH-1:0]   be_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t last_gnt, last_gnt_next;
  // On a conflict the requester that did not win last time takes the slot.
  assign ls_pick = bus.ls_req & (~bus.if_req | (last_gnt == OWN_IF));
`else
  assign ls_pick = bus.ls_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      lat_cnt  <= 3'd0;
      owner    <= OWN_IF;
      owner_we <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt <= OWN_IF;
`endif
    end else begin
      state    <= state_next;
      lat_cnt  <= lat_cnt_next;
      owner    <= owner_next;
      owner_we <= owner_we_next;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt <= last_gnt_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    lat_cnt_next  = lat_cnt;
    owner_next    = owner;
    owner_we_next = owner_we;
`ifdef ARB_ROUND_ROBIN_EN
    last_gnt_next = last_gnt;
`endif
    we_mux        = 1'b0;
    addr_mux      = '0;
    be_mux        = '0;
    wdata_mux     = '0;

    resp   = (state == BUSY) && (lat_cnt == LAT);
    free   = (state == IDLE) || resp;
    ls_gnt = rst & free & ls_pick;
    if_gnt = rst & free & bus.if_req & ~ls_pick;
    gnt    = ls_gnt | if_gnt;

    if (ls_gnt) begin
      we_mux    = bus.ls_we;
      addr_mux  = bus.ls_addr;
      be_mux    = bus.ls_be;
      wdata_mux = bus.ls_wdata;
    end else if (if_gnt) begin
      addr_mux  = bus.if_addr;
      be_mux    = {BE_WIDTH{1'b1}};
    end

    case (state)
      IDLE: begin
        if (gnt) begin
          state_next   = BUSY;
          lat_cnt_next = 3'd1;
        end
      end
      BUSY: begin
        // The response cycle doubles as a free slot so accesses can run back-to-back.
        if (!resp) begin
          lat_cnt_next = lat_cnt + 3'd1;
        end else if (gnt) begin
          lat_cnt_next = 3'd1;
        end else begin
          state_next   = IDLE;
          lat_cnt_next = 3'd0;
        end
      end
      default: begin
        state_next   = IDLE;
        lat_cnt_next = 3'd0;
      end
    endcase

    if (gnt) begin
      owner_next    = ls_gnt ? OWN_LS : OWN_IF;
      owner_we_next = ls_gnt & bus.ls_we;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt_next = ls_gnt ? OWN_LS : OWN_IF;
`endif
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.ls_gnt    = ls_gnt;
  assign bus.mem_en    = gnt;
  assign bus.mem_we    = we_mux;
  assign bus.mem_be    = be_mux;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.busy      = (state == BUSY);

  assign bus.if_rvalid = rst & resp & (owner == OWN_IF);
  assign bus.ls_rvalid = rst & resp & (owner == OWN_LS);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  // Store acknowledgements carry no data.
  assign bus.ls_rdata  = (bus.ls_rvalid && !owner_we) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LAT = 3;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Next-cycle stimulus.
  logic          n_rst, n_if_req, n_ls_req, n_ls_we;
  logic [AW-1:0] n_if_addr, n_ls_addr;
  logic [BW-1:0] n_ls_be;
  logic [DW-1:0] n_ls_wdata;

  // Reference model: one outstanding access known by its due cycle.
  bit            m_busy, m_own_ls, m_last_ls;
  int            m_due;
  logic [DW-1:0] m_data;
  logic [DW-1:0] ref_mem [256];

  // Memory environment driven only by what the DUT puts on the bus.
  logic [DW-1:0] env_mem [256];
  rd_t           rd_q [$];

  // Snapshot of the previous cycle, applied at the next cycle boundary.
  bit            p_rst, e_if_gnt, e_ls_gnt, c_en, c_we, g_ls_we;
  logic [AW-1:0] c_addr, g_ls_addr, g_if_addr;
  logic [BW-1:0] c_be, g_ls_be;
  logic [DW-1:0] c_wdata, g_ls_wdata;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic tick();
    rd_t tmp;
    bit  free, resp, ls_pick;
    @(negedge clk);
    if (!p_rst) begin
      m_busy    = 1'b0;
      m_last_ls = 1'b0;
      rd_q.delete();
    end else begin
      if (c_en) begin
        if (c_we) env_mem[c_addr] = merge(env_mem[c_addr], c_wdata, c_be);
        else begin
          tmp.data = env_mem[c_addr];
          tmp.due  = cyc + LAT;
          rd_q.push_back(tmp);
        end
      end
      if (e_ls_gnt || e_if_gnt) begin
        m_busy    = 1'b1;
        m_due     = cyc + LAT;
        m_own_ls  = e_ls_gnt;
        m_last_ls = e_ls_gnt;
        if (e_ls_gnt) begin
          if (g_ls_we) begin
            ref_mem[g_ls_addr] = merge(ref_mem[g_ls_addr], g_ls_wdata, g_ls_be);
            m_data = '0;
          end else m_data = ref_mem[g_ls_addr];
        end else m_data = ref_mem[g_if_addr];
      end else if (m_busy && m_due == cyc) m_busy = 1'b0;
    end
    cyc++;

    rst          = n_rst;
    bus.if_req   = n_if_req;
    bus.if_addr  = n_if_addr;
    bus.ls_req   = n_ls_req;
    bus.ls_we    = n_ls_we;
    bus.ls_be    = n_ls_be;
    bus.ls_addr  = n_ls_addr;
    bus.ls_wdata = n_ls_wdata;
    while (rd_q.size() > 0 && rd_q[0].due < cyc) void'(rd_q.pop_front());
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      bus.mem_rdata = rd_q[0].data;
      void'(rd_q.pop_front());
    end else bus.mem_rdata = $urandom;
    #1;

    resp     = m_busy && (m_due == cyc);
    free     = !m_busy || resp;
    ls_pick  = n_ls_req && (!n_if_req || !RR || !m_last_ls);
    e_ls_gnt = n_rst && free && ls_pick;
    e_if_gnt = n_rst && free && n_if_req && !ls_pick;

    if (n_rst) begin
      check("ls_gnt", bus.ls_gnt, e_ls_gnt);
      check("if_gnt", bus.if_gnt, e_if_gnt);
      check("mem_en", bus.mem_en, e_ls_gnt || e_if_gnt);
      check("mem_we", bus.mem_we, e_ls_gnt && n_ls_we);
      check("mem_be", bus.mem_be, e_ls_gnt ? n_ls_be : (e_if_gnt ? {BW{1'b1}} : '0));
      check("mem_addr", bus.mem_addr, e_ls_gnt ? n_ls_addr : (e_if_gnt ? n_if_addr : '0));
      check("mem_wdata", bus.mem_wdata, e_ls_gnt ? n_ls_wdata : '0);
      check("busy", bus.busy, m_busy);
      check("if_rvalid", bus.if_rvalid, resp && !m_own_ls);
      check("ls_rvalid", bus.ls_rvalid, resp && m_own_ls);
      check("if_rdata", bus.if_rdata, (resp && !m_own_ls) ? m_data : '0);
      check("ls_rdata", bus.ls_rdata, (resp && m_own_ls) ? m_data : '0);
    end

    p_rst      = n_rst;
    c_en       = bus.mem_en;
    c_we       = bus.mem_we;
    c_addr     = bus.mem_addr;
    c_be       = bus.mem_be;
    c_wdata    = bus.mem_wdata;
    g_ls_we    = n_ls_we;
    g_ls_addr  = n_ls_addr;
    g_ls_be    = n_ls_be;
    g_ls_wdata = n_ls_wdata;
    g_if_addr  = n_if_addr;
  endtask

  // A pending ungranted request holds its fields; it may be dropped before its grant.
  task automatic rand_reqs();
    n_rst = ($urandom_range(0, 199) != 0);
    if (n_if_req && !e_if_gnt) begin
      if ($urandom_range(0, 7) == 0) n_if_req = 1'b0;
    end else begin
      n_if_req  = 1'($urandom_range(0, 1));
      n_if_addr = AW'($urandom_range(0, 15) * 4);
    end
    if (n_ls_req && !e_ls_gnt) begin
      if ($urandom_range(0, 7) == 0) n_ls_req = 1'b0;
    end else begin
      n_ls_req   = 1'($urandom_range(0, 1));
      n_ls_we    = ($urandom_range(0, 2) == 0);
      n_ls_be    = BW'($urandom_range(1, 15));
      n_ls_addr  = AW'($urandom_range(0, 15) * 4);
      n_ls_wdata = $urandom;
    end
  endtask

  task automatic quiet(input int n);
    n_if_req = 1'b0;
    n_ls_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int   busy_cnt;
    bit   seen;
    bit   seq [$];

    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      ref_mem[i] = env_mem[i];
    end
    env_mem[8'h04] = 32'h00500093; ref_mem[8'h04] = 32'h00500093;
    env_mem[8'h08] = 32'h00A00113; ref_mem[8'h08] = 32'h00A00113;
    env_mem[8'h40] = 32'hCAFE0040; ref_mem[8'h40] = 32'hCAFE0040;

    n_rst = 1'b0; n_if_req = 1'b0; n_ls_req = 1'b0; n_ls_we = 1'b0;
    n_if_addr = '0; n_ls_addr = '0; n_ls_be = '0; n_ls_wdata = '0;
    p_rst = 1'b0; e_if_gnt = 1'b0; e_ls_gnt = 1'b0; c_en = 1'b0; c_we = 1'b0;
    bus.mem_rdata = '0;
    tick();
    tick();

    n_rst = 1'b1;
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_mem_en", bus.mem_en, 1'b0);
    check("rst_rvalid", {bus.if_rvalid, bus.ls_rvalid}, 2'b00);
    check("rst_rdata", {bus.if_rdata, bus.ls_rdata}, 64'h0);

    // Single IFU fetch.
    n_if_req = 1'b1; n_if_addr = 8'h04;
    tick();
    check("fetch_if_gnt", bus.if_gnt, 1'b1);
    check("fetch_mem_en", bus.mem_en, 1'b1);
    n_if_req = 1'b0;
    busy_cnt = 0;
    for (int i = 1; i <= LAT + 2; i++) begin
      tick();
      busy_cnt += int'(bus.busy);
      if (i == LAT) begin
        check("fetch_if_rvalid", bus.if_rvalid, 1'b1);
        check("fetch_if_rdata", bus.if_rdata, 32'h00500093);
      end
    end
    check("fetch_busy_cycles", busy_cnt, LAT);

    // Conflict: LSU load wins, IFU takes the response-cycle slot.
    n_if_req = 1'b1; n_if_addr = 8'h08;
    n_ls_req = 1'b1; n_ls_we = 1'b0; n_ls_be = 4'hF; n_ls_addr = 8'h40;
    tick();
    check("conf_ls_first", bus.ls_gnt, 1'b1);
    check("conf_if_wait", bus.if_gnt, 1'b0);
    n_ls_req = 1'b0;
    for (int i = 1; i <= LAT; i++) tick();
    check("conf_ls_rvalid", bus.ls_rvalid, 1'b1);
    check("conf_ls_rdata", bus.ls_rdata, 32'hCAFE0040);
    check("conf_if_gnt_b2b", bus.if_gnt, 1'b1);
    n_if_req = 1'b0;
    for (int i = 1; i <= LAT; i++) tick();
    check("conf_if_rvalid", bus.if_rvalid, 1'b1);
    check("conf_if_rdata", bus.if_rdata, 32'h00A00113);

    // Both requesters held high across six grants, from a fresh reset.
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    n_if_req = 1'b1; n_ls_req = 1'b1;
    for (int i = 0; i < 60 && seq.size() < 6; i++) begin
      tick();
      if (bus.ls_gnt) seq.push_back(1'b1);
      if (bus.if_gnt) seq.push_back(1'b0);
    end
    check("order_count", seq.size(), 6);
    for (int k = 0; k < seq.size(); k++)
      check($sformatf("order_%0d", k), seq[k], RR ? (k % 2 == 0) : 1'b1);
    quiet(LAT + 1);

    // Partial store and its acknowledgement.
    n_ls_req = 1'b1; n_ls_we = 1'b1; n_ls_be = 4'b0011; n_ls_addr = 8'h20; n_ls_wdata = 32'hDEADBEEF;
    tick();
    check("st_mem_we", bus.mem_we, 1'b1);
    check("st_mem_be", bus.mem_be, 4'b0011);
    check("st_mem_addr", bus.mem_addr, 8'h20);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    n_ls_req = 1'b0; n_ls_we = 1'b0;
    for (int i = 1; i <= LAT; i++) tick();
    check("st_ls_rvalid", bus.ls_rvalid, 1'b1);
    check("st_ls_rdata", bus.ls_rdata, 32'h0);
    quiet(2);

    // Reset while an access is outstanding.
    n_if_req = 1'b1; n_if_addr = 8'h04;
    tick();
    n_if_req = 1'b0;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    check("abort_busy", bus.busy, 1'b0);
    check("abort_mem_en", bus.mem_en, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      seen |= bus.if_rvalid | bus.ls_rvalid;
    end
    check("abort_no_rvalid", seen, 1'b0);
    n_ls_req = 1'b1; n_ls_we = 1'b0; n_ls_addr = 8'h40; n_ls_be = 4'hF;
    tick();
    check("abort_regrant", bus.ls_gnt, 1'b1);
    quiet(LAT + 1);

    // Request pulsed while busy and withdrawn before the slot frees.
    n_if_req = 1'b1; n_if_addr = 8'h08;
    tick();
    n_if_req = 1'b0;
    n_ls_req = 1'b1;
    tick();
    seen = bus.ls_gnt | bus.mem_en;
    n_ls_req = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      seen |= bus.ls_gnt | bus.mem_en;
    end
    check("pulse_no_grant", seen, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      rand_reqs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
